// File: rtl/arbitro_rr_mux.sv
// Round-robin scheduler for the shared 4:1 mux / 1:4 demux between input and output FIFOs.
// Grants are combinational from state, pointer and flags so that pop and the flags it used share one edge.
module arbitro_rr_mux #(
  parameter int INIT_CYCLES = 4,
  parameter int NUM_PUERTOS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PUERTOS-1:0]         vacio,
  input  logic [NUM_PUERTOS-1:0]         pausa,
  input  logic [$clog2(NUM_PUERTOS)-1:0] destino0,
  input  logic [$clog2(NUM_PUERTOS)-1:0] destino1,
  input  logic [$clog2(NUM_PUERTOS)-1:0] destino2,
  input  logic [$clog2(NUM_PUERTOS)-1:0] destino3,
  output logic [NUM_PUERTOS-1:0]         pop,
  output logic [NUM_PUERTOS-1:0]         push,
  output logic [$clog2(NUM_PUERTOS)-1:0] selector_mux,
  output logic [$clog2(NUM_PUERTOS)-1:0] selector_demux,
  output logic                           enb,
  output logic                           idle
);
  // state  | meaning
  // INICIO | settling after reset, no grants
  // IDLE   | nothing was granted last cycle
  // ACTIVO | a grant was issued last cycle

  localparam int SW       = $clog2(NUM_PUERTOS);
  localparam int INIT_EFF = (INIT_CYCLES < 1) ? 1 : INIT_CYCLES;
  localparam int CW       = $clog2(INIT_EFF + 1);

  typedef enum logic [1:0] {INICIO, IDLE, ACTIVO} estado_t;

  estado_t                estado;
  logic [SW-1:0]          ptr;
  logic [CW-1:0]          cnt;
  logic [SW-1:0]          dest [NUM_PUERTOS];
  logic [NUM_PUERTOS-1:0] elig;
  logic                   hay;
  logic                   grant;
  logic [SW-1:0]          gan;
  logic [SW-1:0]          idx;

  assign dest[0] = destino0;
  assign dest[1] = destino1;
  assign dest[2] = destino2;
  assign dest[3] = destino3;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_PUERTOS; i++)
      elig[i] = !vacio[i] && !pausa[dest[i]];
  end

  // Scan starts at ptr so the most recently served input goes last.
  always_comb begin
    hay = 1'b0;
    gan = '0;
    idx = '0;
    for (int k = 0; k < NUM_PUERTOS; k++) begin
      idx = ptr + SW'(k);
      if (!hay && elig[idx]) begin
        hay = 1'b1;
        gan = idx;
      end
    end
  end

  assign grant = hay && (estado != INICIO);

  always_comb begin
    pop            = '0;
    push           = '0;
    selector_mux   = '0;
    selector_demux = '0;
    enb            = 1'b0;
    idle           = 1'b0;
    if (grant) begin
      pop[gan]       = 1'b1;
      push[dest[gan]] = 1'b1;
      selector_mux   = gan;
      selector_demux = dest[gan];
      enb            = 1'b1;
    end else if (estado == IDLE) begin
      idle = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= INICIO;
      ptr    <= '0;
      cnt    <= '0;
    end else begin
      case (estado)
        INICIO: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(INIT_EFF - 1)) estado <= IDLE;
        end
        IDLE:    if (grant) estado <= ACTIVO;
        ACTIVO:  if (!grant) estado <= IDLE;
        default: estado <= INICIO;
      endcase
      if (grant) ptr <= gan + SW'(1);
    end
  end

endmodule
